dut_word_packer: RTL and testbench

Downstream stage of the byte-stream interface block. It drains the 8-bit `dout` actionvalue method (`dout_en`/`dout_value`/`dout_rdy`) and packs bytes little-endian into 32-bit words. Each frame's length comes from a per-frame length handshake, and the final word of a frame is marked with byte enables and a last flag. Output words leave on a valid/ready port toward the word-wide consumer, and completed frames are counted.

---
 rtl/dut_word_packer.sv | 222 ++++++++++++++++++++++
 tb/tb_dut_word_packer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dut_word_packer.sv
// dut_word_packer
// Drains a byte stream (in_rdy/in_en/in_value) and packs it little-endian
// into 32-bit words. Each frame's length is loaded through len_en/len_rdy;
// the final word of a frame carries partial byte enables and out_last.
// Words leave through a single-entry valid/ready output register while a
// separate 3-byte accumulator keeps filling the next word.
// Optional feature: define PACKER_PARITY_EN to add out_parity[3:0]
// (per-lane even parity, zero for disabled lanes).
module dut_word_packer #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [7:0]       in_value,
  input  logic             in_rdy,
  output logic             in_en,
  input  logic [7:0]       len_value,
  input  logic             len_en,
  output logic             len_rdy,
  output logic [31:0]      out_word,
  output logic [3:0]       out_be,
  output logic             out_last,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PACKER_PARITY_EN
  output logic [3:0]       out_parity,
`endif
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  // Control state
  state_t           r_state;
  state_t           w_state_nxt;
  logic [8:0]       r_remaining;   // bytes still to accept in this frame (1..256)
  logic [1:0]       r_idx;         // next lane to fill
  logic [23:0]      r_acc;         // lanes 0..2 of the word being built

  // Output register
  logic [31:0]      r_word;
  logic [3:0]       r_be;
  logic             r_last;
  logic             r_valid;
  logic [CNT_W-1:0] r_count;
`ifdef PACKER_PARITY_EN
  logic [3:0]       r_parity;
`endif

  // Combinational helpers
  logic             w_completing;
  logic             w_last_byte;
  logic             w_blocked;
  logic             w_take;
  logic             w_len_take;
  logic             w_handshake;
  logic             w_load;
  logic [31:0]      w_word_nxt;
  logic [3:0]       w_be_nxt;

`ifdef PACKER_PARITY_EN
  // Per-lane parity bit: XOR of the lane, forced to 0 for disabled lanes.
  function automatic logic [3:0] lane_parity(input logic [31:0] word,
                                             input logic [3:0]  be);
    logic [3:0] p;
    p = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      p[k] = (^word[8*k +: 8]) & be[k];
    end
    return p;
  endfunction
`endif

  // A byte closes the current word when it fills lane 3 or ends the frame.
  assign w_last_byte  = (r_remaining == 9'd1);
  assign w_completing = (r_idx == 2'd3) || w_last_byte;
  assign w_handshake  = r_valid && out_ready;

  // A completing byte cannot be taken while the output register is still
  // occupied and not being drained this cycle; partial bytes always can.
  assign w_blocked    = w_completing && r_valid && !out_ready;
  assign w_take       = (r_state == S_FILL) && in_rdy && !w_blocked;
  assign w_load       = w_take && w_completing;
  assign w_len_take   = (r_state == S_IDLE) && len_en;

  assign in_en        = w_take;
  assign len_rdy      = (r_state == S_IDLE);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: a length starts a frame, the frame's last byte ends it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (len_en) begin
          w_state_nxt = S_FILL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FILL: begin
        if (w_take && w_last_byte) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_FILL;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Assemble the outgoing word: accumulated lanes below idx plus the new
  // byte at lane idx; lanes above idx stay zero.
  always_comb begin
    w_word_nxt = 32'h0000_0000;
    w_be_nxt   = 4'b0000;
    case (r_idx)
      2'd0: begin
        w_word_nxt = {24'h00_0000, in_value};
        w_be_nxt   = 4'b0001;
      end
      2'd1: begin
        w_word_nxt = {16'h0000, in_value, r_acc[7:0]};
        w_be_nxt   = 4'b0011;
      end
      2'd2: begin
        w_word_nxt = {8'h00, in_value, r_acc[15:0]};
        w_be_nxt   = 4'b0111;
      end
      2'd3: begin
        w_word_nxt = {in_value, r_acc};
        w_be_nxt   = 4'b1111;
      end
      default: begin
        w_word_nxt = 32'h0000_0000;
        w_be_nxt   = 4'b0000;
      end
    endcase
  end

  // Frame bookkeeping and accumulator: load length, then track lane/remaining.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_remaining <= 9'd0;
      r_idx       <= 2'd0;
      r_acc       <= 24'h00_0000;
    end else if (w_len_take) begin
      r_remaining <= (len_value == 8'd0) ? 9'd256 : {1'b0, len_value};
      r_idx       <= 2'd0;
      r_acc       <= 24'h00_0000;
    end else if (w_take) begin
      r_remaining <= r_remaining - 9'd1;
      if (w_completing) begin
        r_idx <= 2'd0;
        r_acc <= 24'h00_0000;
      end else begin
        r_idx <= r_idx + 2'd1;
        case (r_idx)
          2'd0:    r_acc[7:0]   <= in_value;
          2'd1:    r_acc[15:8]  <= in_value;
          2'd2:    r_acc[23:16] <= in_value;
          default: r_acc        <= r_acc;
        endcase
      end
    end
  end

  // Output register: a reload wins over the drain of the previous word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_word   <= 32'h0000_0000;
      r_be     <= 4'b0000;
      r_last   <= 1'b0;
      r_valid  <= 1'b0;
`ifdef PACKER_PARITY_EN
      r_parity <= 4'b0000;
`endif
    end else if (w_load) begin
      r_word   <= w_word_nxt;
      r_be     <= w_be_nxt;
      r_last   <= w_last_byte;
      r_valid  <= 1'b1;
`ifdef PACKER_PARITY_EN
      r_parity <= lane_parity(w_word_nxt, w_be_nxt);
`endif
    end else if (w_handshake) begin
      r_valid  <= 1'b0;
    end
  end

  // Completed-frame counter: one count per delivered last word, wrapping.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_count <= {CNT_W{1'b0}};
    end else if (w_handshake && r_last) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign out_word    = r_word;
  assign out_be      = r_be;
  assign out_last    = r_last;
  assign out_valid   = r_valid;
  assign frame_count = r_count;
`ifdef PACKER_PARITY_EN
  assign out_parity  = r_parity;
`endif

endmodule

// File: tb/tb_dut_word_packer.sv
// Self-checking bench for dut_word_packer: table of frames plus directed
// stall / reset / back-to-back sequences, with a word scoreboard.
`timescale 1ns/1ps
module tb_dut_word_packer;
  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [7:0]       in_value;
  logic             in_rdy;
  logic             in_en;
  logic [7:0]       len_value = 8'h00;
  logic             len_en = 1'b0;
  logic             len_rdy;
  logic [31:0]      out_word;
  logic [3:0]       out_be;
  logic             out_last;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] frame_count;
`ifdef PACKER_PARITY_EN
  logic [3:0]       out_parity;
`endif

  dut_word_packer #(.CNT_W(CNT_W)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .in_value    (in_value),
    .in_rdy      (in_rdy),
    .in_en       (in_en),
    .len_value   (len_value),
    .len_en      (len_en),
    .len_rdy     (len_rdy),
    .out_word    (out_word),
    .out_be      (out_be),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
`ifdef PACKER_PARITY_EN
    .out_parity  (out_parity),
`endif
    .frame_count (frame_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  be;
    logic        last;
  } exp_t;

  typedef struct {
    logic [7:0]  len;
    logic [7:0]  start;
    logic [7:0]  step;
    int          mode;        // 0: ready low, 1: ready high, 2: random
    int          exp_words;
    logic [31:0] exp_last_word;
    logic [3:0]  exp_last_be;
  } vec_t;

  exp_t        exp_q[$];
  logic [7:0]  tx_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          ready_mode = 1;
  int          hold_at = 0;
  logic        byte_taken = 1'b0;
  int          words_seen = 0;
  logic [31:0] last_word = 32'h0;
  logic [3:0]  last_be = 4'h0;
  logic [3:0]  last_par = 4'h0;
  int          exp_frames = 0;
  vec_t        tbl[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] par_of(input logic [31:0] w, input logic [3:0] be);
    logic [3:0] p;
    for (int k = 0; k < 4; k++) p[k] = (^w[8*k +: 8]) & be[k];
    return p;
  endfunction

  // Byte source: presents queue head, pops it once the DUT has taken it.
  initial begin
    in_rdy = 1'b0;
    in_value = 8'h00;
    forever begin
      @(posedge CLK); #1;
      if (byte_taken && tx_q.size() > 0) void'(tx_q.pop_front());
      byte_taken = 1'b0;
      if (tx_q.size() > hold_at) begin
        in_rdy = 1'b1;
        in_value = tx_q[0];
      end else begin
        in_rdy = 1'b0;
        in_value = 8'h00;
      end
    end
  end

  // Consumer ready pattern.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge CLK); #1;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Scoreboard monitor: every pending word must match the queue head.
  always @(negedge CLK) begin
    byte_taken = in_en;
    if (RST) begin
      exp_q.delete();
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", out_word, 32'hxxxx_xxxx);
      end else begin
        check("word", out_word, exp_q[0].word);
        check("be", 32'(out_be), 32'(exp_q[0].be));
        check("last", 32'(out_last), 32'(exp_q[0].last));
`ifdef PACKER_PARITY_EN
        check("parity", 32'(out_parity), 32'(par_of(exp_q[0].word, exp_q[0].be)));
`endif
        if (out_ready) begin
          words_seen++;
          if (out_last) begin
            last_word = out_word;
            last_be = out_be;
`ifdef PACKER_PARITY_EN
            last_par = out_parity;
`endif
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic push_frame(input logic [7:0] len, input logic [7:0] start, input logic [7:0] step);
    int n;
    int lane;
    logic [31:0] w;
    logic [3:0] be;
    logic [7:0] b;
    n = (len == 8'd0) ? 256 : int'(len);
    w = 32'h0; be = 4'h0; lane = 0;
    for (int i = 0; i < n; i++) begin
      b = start + 8'(i) * step;
      w[8*lane +: 8] = b;
      be[lane] = 1'b1;
      tx_q.push_back(b);
      if (lane == 3 || i == n - 1) begin
        exp_q.push_back('{w, be, (i == n - 1)});
        w = 32'h0; be = 4'h0; lane = 0;
      end else begin
        lane++;
      end
    end
  endtask

  task automatic send_len(input logic [7:0] v);
    int n;
    logic acc;
    n = 0;
    @(posedge CLK); #1;
    len_value = v;
    len_en = 1'b1;
    @(negedge CLK);
    while (!len_rdy && n < 300) begin
      @(negedge CLK);
      n++;
    end
    acc = len_rdy;
    @(posedge CLK); #1;
    len_en = 1'b0;
    check("len_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("drain_timeout", 32'(n < budget), 32'd1);
    @(posedge CLK); #1;
    @(negedge CLK);
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST = 1'b1;
    tx_q.delete();
    repeat (2) @(negedge CLK);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_in_en", 32'(in_en), 32'd0);
    check("rst_word", out_word, 32'd0);
    check("rst_be", 32'(out_be), 32'd0);
    check("rst_len_rdy", 32'(len_rdy), 32'd1);
    check("rst_frame_count", 32'(frame_count), 32'd0);
`ifdef PACKER_PARITY_EN
    check("rst_parity", 32'(out_parity), 32'd0);
`endif
    @(posedge CLK); #1;
    RST = 1'b0;
    exp_frames = 0;
  endtask

  initial begin
    int ws0;
    int n;
    tbl[0] = '{8'd4, 8'h11, 8'h11, 1, 1,  32'h4433_2211, 4'hF};
    tbl[1] = '{8'd6, 8'h01, 8'h01, 1, 2,  32'h0000_0605, 4'h3};
    tbl[2] = '{8'd1, 8'hAA, 8'h00, 1, 1,  32'h0000_00AA, 4'h1};
    tbl[3] = '{8'd7, 8'h10, 8'h01, 2, 2,  32'h0016_1514, 4'h7};
    tbl[4] = '{8'd0, 8'h00, 8'h01, 1, 64, 32'hFFFE_FDFC, 4'hF};
    tbl[5] = '{8'd3, 8'hF0, 8'h0F, 2, 1,  32'h000E_FFF0, 4'h7};
    tbl[6] = '{8'd5, 8'h80, 8'h02, 2, 2,  32'h0000_0088, 4'h1};

    ready_mode = 1;
    do_reset();

    // Table-driven frames.
    for (int t = 0; t < 7; t++) begin
      ready_mode = tbl[t].mode;
      ws0 = words_seen;
      push_frame(tbl[t].len, tbl[t].start, tbl[t].step);
      send_len(tbl[t].len);
      wait_drain(3000);
      exp_frames++;
      check($sformatf("v%0d_words", t), 32'(words_seen - ws0), 32'(tbl[t].exp_words));
      check($sformatf("v%0d_last_word", t), last_word, tbl[t].exp_last_word);
      check($sformatf("v%0d_last_be", t), 32'(last_be), 32'(tbl[t].exp_last_be));
      check($sformatf("v%0d_frame_count", t), 32'(frame_count), 32'(exp_frames));
      check($sformatf("v%0d_idle_valid", t), 32'(out_valid), 32'd0);
    end

    // Backpressure: length 12 with consumer stalled.
    ready_mode = 0;
    ws0 = words_seen;
    push_frame(8'd12, 8'h01, 8'h01);
    send_len(8'd12);
    repeat (20) @(negedge CLK);
    check("stall_valid", 32'(out_valid), 32'd1);
    check("stall_word", out_word, 32'h0403_0201);
    check("stall_in_en", 32'(in_en), 32'd0);
    check("stall_bytes_left", 32'(tx_q.size()), 32'd5);
    ready_mode = 1;
    wait_drain(500);
    exp_frames++;
    check("stall_words", 32'(words_seen - ws0), 32'd3);
    check("stall_last_word", last_word, 32'h0C0B_0A09);
    check("stall_frame_count", 32'(frame_count), 32'(exp_frames));

    // Reset in the middle of a length-8 frame after 5 bytes.
    ready_mode = 1;
    hold_at = 3;
    push_frame(8'd8, 8'h01, 8'h01);
    send_len(8'd8);
    n = 0;
    while (tx_q.size() > 3 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("mid_timeout", 32'(n < 100), 32'd1);
    repeat (3) @(negedge CLK);
    do_reset();
    hold_at = 0;
    push_frame(8'd1, 8'hAA, 8'h00);
    send_len(8'd1);
    wait_drain(200);
    check("post_rst_word", last_word, 32'h0000_00AA);
    check("post_rst_be", 32'(last_be), 32'd1);
    check("post_rst_frame_count", 32'(frame_count), 32'd1);

    // 256-byte frame whose last word is stalled; next length accepted meanwhile.
    do_reset();
    ready_mode = 1;
    hold_at = 4;
    push_frame(8'd0, 8'h00, 8'h01);
    send_len(8'd0);
    n = 0;
    while (tx_q.size() > 4 && n < 600) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_fill_timeout", 32'(n < 600), 32'd1);
    repeat (3) @(posedge CLK);
    #1;
    ready_mode = 0;
    hold_at = 0;
    n = 0;
    @(negedge CLK);
    while (!(out_valid && out_last) && n < 60) begin
      @(negedge CLK);
      n++;
    end
    check("b2b_last_timeout", 32'(n < 60), 32'd1);
    check("b2b_pending_word", out_word, 32'hFFFE_FDFC);
    check("b2b_pending_count", 32'(frame_count), 32'd0);
    check("b2b_len_rdy", 32'(len_rdy), 32'd1);
    send_len(8'd2);
    push_frame(8'd2, 8'h07, 8'hFC);
    repeat (6) @(negedge CLK);
    check("b2b_hold_word", out_word, 32'hFFFE_FDFC);
    check("b2b_in_en", 32'(in_en), 32'd0);
    check("b2b_bytes_left", 32'(tx_q.size()), 32'd1);
    ready_mode = 1;
    wait_drain(200);
    check("b2b_last_word", last_word, 32'h0000_0307);
    check("b2b_last_be", 32'(last_be), 32'd3);
    check("b2b_frame_count", 32'(frame_count), 32'd2);
`ifdef PACKER_PARITY_EN
    check("b2b_parity", 32'(last_par), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
